// File: rtl/core_run_ctrl.sv
// Run/halt/single-step sequencer for the RV32I core: gates commit via core_en,
// with a post-reset hold, one PC breakpoint and cycle/instret counters.
module core_run_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter bit          START_RUN   = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             clr_cnt,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             core_en,
    output logic             halted,
    output logic             bp_hit,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10,
        S_STEP = 2'b11
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              bp_skip_q;
    logic              bp_hit_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [CNT_W-1:0]  instret_cnt_q;

    logic              bp_match;
    logic              bp_stop;
    logic              resume;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = START_RUN ? S_RUN : S_HALT;
                end
            end
            S_RUN: begin
                if (bp_match || halt_req) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (step_req) begin
                    state_d = S_STEP;
                end else if (run_req) begin
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    // Commit gating and state-derived strobes; a step always commits, even on the breakpoint
    always_comb begin
        bp_match = bp_en && (pc == bp_addr) && !bp_skip_q;
        core_en  = 1'b0;
        halted   = 1'b0;
        bp_stop  = 1'b0;
        resume   = 1'b0;
        case (state_q)
            S_RUN: begin
                core_en = !bp_match;
                bp_stop = bp_match;
            end
            S_HALT: begin
                halted = 1'b1;
                resume = step_req || run_req;
            end
            S_STEP: begin
                core_en = 1'b1;
            end
            default: begin
                core_en = 1'b0;
            end
        endcase
    end

    // Post-reset hold timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_q <= '0;
        end else if (state_q == S_HOLD && hold_cnt_q != HOLD_LAST) begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
        end
    end

    // Breakpoint status; skip lets a resume at bp_addr execute that instruction once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_skip_q <= 1'b0;
            bp_hit_q  <= 1'b0;
        end else begin
            if (resume) begin
                bp_skip_q <= 1'b1;
            end else if (core_en) begin
                bp_skip_q <= 1'b0;
            end
            if (resume) begin
                bp_hit_q <= 1'b0;
            end else if (bp_stop) begin
                bp_hit_q <= 1'b1;
            end
        end
    end

    // Free-wrapping performance counters, clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else if (clr_cnt) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != S_HOLD) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (core_en) begin
                instret_cnt_q <= instret_cnt_q + CNT_W'(1);
            end
        end
    end

    assign state       = state_q;
    assign bp_hit      = bp_hit_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule
